load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the control unit.
- Consumes memWrite, memRead and memRWSize, plus the ALU address and the rs2 store data.
- Drives a req/ack data bus with byte enables.
- Stalls the core until the access completes.
- Returns sign- or zero-extended load data for the WB_DATA_MEM writeback path.
- Flags misaligned and illegal accesses, and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, BUS-state cycles without bus_ack before the access is aborted with bus_err (1..65535).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
memRead  in  1  load request (top level drives WBSel==WB_DATA_MEM)
memWrite  in  1  store request from control unit
memRWSize  in  3  access size/sign, MEM_* encoding
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  core must hold PC and instruction
done  out  1  one-cycle pulse, access retired
rdata  out  32  extended load data, valid while done=1
fault  out  1  with done: misaligned or illegal size, no bus access made
bus_err  out  1  with done: timeout
bus_req  out  1  bus request, held until ack or timeout
bus_we  out  1  write strobe
bus_addr  out  32  word-aligned address, addr[1:0] forced to 00
bus_be  out  4  byte enables
bus_wdata  out  32  lane-steered store data
bus_ack  in  1  bus completion, single-cycle
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset and state machine
  - One clock; reset is synchronous, active-high.
  - States IDLE, BUS, DONE.
  - Reset values: state=IDLE, counter=0, all registered outputs 0.
  - stall=0 while rst=1.
- Request and stall rules
  - A request is memRead|memWrite.
  - If both are high, the access is a store.
  - stall = (IDLE & request) | BUS. stall is 0 in DONE.
- Fault check in IDLE (combinational on addr/memRWSize)
  - Halfword with addr[0]=1 is a fault.
  - Word with addr[1:0]!=00 is a fault.
  - memRWSize in {011,110,111} is a fault.
  - Store with an unsigned size code is legal and treated as signed.
- IDLE with request and no fault
  - Latch bus_addr={addr[31:2],2'b00}, bus_we=memWrite, bus_be, bus_wdata, size code and addr[1:0].
  - Set bus_req=1 and go to BUS.
- IDLE with request and fault
  - Go to DONE with fault=1 and rdata=0. The bus stays idle.
- BUS state
  - bus_ack=1: drop bus_req. For loads, capture the extracted rdata. Go to DONE.
  - Counter increments each BUS cycle. At TIMEOUT_CYCLES with no ack: drop bus_req, set bus_err=1 and rdata=0, go to DONE.
  - bus_req and all bus_* outputs stay stable while in BUS.
- DONE state
  - done=1 for exactly one cycle, then go to IDLE unconditionally.
  - Core request inputs still high in DONE are not re-accepted.
  - fault, bus_err and the counter clear on leaving DONE.
  - rdata holds its value until the next capture.
- Latency
  - Zero-wait bus (ack in the first BUS cycle): 3 cycles from request to retire (IDLE, BUS, DONE).
  - Each extra wait cycle adds 1.
- Store lanes
  - Byte: wdata[7:0] replicated to all 4 lanes, bus_be=0001<<addr[1:0].
  - Half: wdata[15:0] replicated to both halves, bus_be=addr[1]?1100:0011.
  - Word: bus_be=1111.
- Load extraction
  - Select the byte bus_rdata[8*a+:8] or the halfword bus_rdata[16*addr[1]+:16].
  - MEM_*_SIGNED sign-extends; MEM_*_UNSIGNED zero-extends.
  - Word loads pass bus_rdata through.
  - bus_be=1111 on all loads.
- Ignored inputs: bus_ack in IDLE or DONE, including a late ack after a timeout or reset.
- Reset mid-access: bus_req=0 and state=IDLE after the reset edge. Nothing is retired.

Decomposition:
- Shared package InstrTypes
  - MEM_BYTE_SIGNED=3'b000, MEM_HALFWORD_SIGNED=3'b001, MEM_WORD_SIGNED=3'b010, MEM_BYTE_UNSIGNED=3'b100, MEM_HALFWORD_UNSIGNED=3'b101 (equal to funct3).
  - lsu_state_t enum {IDLE, BUS, DONE}.
- Sub-module lsu_lane_align (combinational)
  - Store steering (bus_be, bus_wdata).
  - Load extraction and extension.
  - Fault detection.
  - Instantiated once; the FSM and counter stay in load_store_unit.

Test Plan:
- lb, addr=0x1003, memRWSize=000, bus_rdata=0x80AA55CC, ack in first BUS cycle -> bus_addr=0x1000, bus_be=1111; done in cycle 3 with rdata=0xFFFFFF80; stall high for 2 cycles.
- lhu, addr=0x2002, bus_rdata=0x9ABC1234, ack after 3 wait cycles -> rdata=0x00009ABC; stall high for 5 cycles.
- sb, addr=0x3001, wdata=0x123456EF -> bus_we=1, bus_be=0010, bus_wdata=0xEFEFEFEF. sw at 0x3004 -> bus_be=1111, bus_wdata=wdata.
- lw at 0x4002; then memRWSize=011 -> each gives fault=1 with done on cycle 2, bus_req never asserted, rdata=0.
- TIMEOUT_CYCLES=4, load with no ack -> bus_req high 4 cycles, then done with bus_err=1, rdata=0; an ack 2 cycles later is ignored.
- rst asserted in the 2nd BUS cycle -> bus_req=0 on the next edge, no done; a following clean lw completes normally.

Source files
------------

// File: rtl/InstrTypes.sv
// Shared encodings between the control unit and the load/store unit:
// memory access size codes (equal to the load/store funct3) and LSU states.
package InstrTypes;

    localparam logic [2:0] MEM_BYTE_SIGNED       = 3'b000;
    localparam logic [2:0] MEM_HALFWORD_SIGNED   = 3'b001;
    localparam logic [2:0] MEM_WORD_SIGNED       = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for stores, byte/halfword extraction and
// extension for loads, and alignment/size fault detection.
module lsu_lane_align
    import InstrTypes::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] steered_wdata,
    output logic        fault,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fault = 1'b0;
        case (size)
            MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: fault = offset[0];
            MEM_WORD_SIGNED:                            fault = (offset != 2'b00);
            MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED:         fault = 1'b0;
            default:                                    fault = 1'b1;
        endcase
    end

    // Stores ignore the sign bit of the size code; loads always fetch the whole word.
    always_comb begin
        be            = 4'b1111;
        steered_wdata = wdata;
        if (is_store) begin
            case (size[1:0])
                2'b00: begin
                    be            = 4'b0001 << offset;
                    steered_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be            = offset[1] ? 4'b1100 : 4'b0011;
                    steered_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    be            = 4'b1111;
                    steered_wdata = wdata;
                end
            endcase
        end
    end

    assign byte_sel = bus_rdata[{ld_offset, 3'b000} +: 8];
    assign half_sel = bus_rdata[{ld_offset[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = bus_rdata;
        case (ld_size[1:0])
            2'b00:   ld_data = ld_size[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ld_data = ld_size[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts a load/store from the control unit, runs
// one req/ack bus transaction, stalls the core meanwhile, and retires with done.
module load_store_unit
    import InstrTypes::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memRWSize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    lsu_state_t  next_state;
    logic [15:0] count;
    logic [2:0]  size_q;
    logic [1:0]  offset_q;
    logic        request;
    logic        timeout_hit;
    logic        fault_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ld_data;

    assign request     = memRead | memWrite;
    assign timeout_hit = (count == COUNT_LAST);

    lsu_lane_align u_align (
        .size          (memRWSize),
        .offset        (addr[1:0]),
        .is_store      (memWrite),
        .wdata         (wdata),
        .be            (be_c),
        .steered_wdata (wdata_c),
        .fault         (fault_c),
        .ld_size       (size_q),
        .ld_offset     (offset_q),
        .bus_rdata     (bus_rdata),
        .ld_data       (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = fault_c ? DONE : BUS;
            BUS:     if (bus_ack || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign stall = !rst && (((state == IDLE) && request) || (state == BUS));
    assign done  = (state == DONE);

    // NOTE: reset is synchronous; only control and output registers need a known value,
    // but the captured bus fields are cleared too so every output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            size_q    <= '0;
            offset_q  <= '0;
            rdata     <= '0;
            fault     <= 1'b0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (fault_c) begin
                            fault <= 1'b1;
                            rdata <= '0;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= memWrite;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_c;
                            bus_wdata <= wdata_c;
                            size_q    <= memRWSize;
                            offset_q  <= addr[1:0];
                            count     <= '0;
                        end
                    end
                end
                BUS: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) rdata <= ld_data;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                DONE: begin
                    fault   <= 1'b0;
                    bus_err <= 1'b0;
                    count   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and
// mid-access reset, with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memRWSize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memRWSize (memRWSize),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; bus_ack defaults to a single-cycle pulse.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b1; memWrite = 1'b0; memRWSize = 3'b000;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

        // Reset: outputs zero, stall suppressed even with a request present
        sample();
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_rdata", rdata, 0);
        check("rst_fault", {fault, bus_err}, 0);
        next_cycle();
        rst = 1'b0; memRead = 1'b0;
        sample();
        check("idle_stall", stall, 0);

        // lb at 0x1003, ack in first BUS cycle
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b000; addr = 32'h0000_1003;
        sample();
        check("lb_c1_stall", stall, 1);
        check("lb_c1_bus_req", bus_req, 0);
        next_cycle();
        bus_ack = 1'b1; bus_rdata = 32'h80AA_55CC;
        sample();
        check("lb_c2_stall", stall, 1);
        check("lb_bus_req", bus_req, 1);
        check("lb_bus_addr", bus_addr, 32'h0000_1000);
        check("lb_bus_be", bus_be, 32'hF);
        check("lb_bus_we", bus_we, 0);
        next_cycle();
        sample();
        check("lb_c3_done", done, 1);
        check("lb_c3_stall", stall, 0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_bus_req_drop", bus_req, 0);
        next_cycle();
        memRead = 1'b0;
        sample();
        check("lb_no_reaccept", {done, stall, bus_req}, 0);

        // lhu at 0x2002, three wait cycles then ack
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b101; addr = 32'h0000_2002;
        sample();
        check("lhu_c1_stall", stall, 1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("lhu_wait_stall", stall, 1);
            check("lhu_wait_req", bus_req, 1);
            check("lhu_wait_done", done, 0);
        end
        next_cycle();
        bus_ack = 1'b1; bus_rdata = 32'h9ABC_1234;
        sample();
        check("lhu_c5_stall", stall, 1);
        check("lhu_bus_addr", bus_addr, 32'h0000_2000);
        next_cycle();
        sample();
        check("lhu_done", done, 1);
        check("lhu_stall_off", stall, 0);
        check("lhu_rdata", rdata, 32'h0000_9ABC);
        next_cycle();
        memRead = 1'b0;

        // sb at 0x3001
        next_cycle();
        memWrite = 1'b1; memRWSize = 3'b000; addr = 32'h0000_3001; wdata = 32'h1234_56EF;
        sample();
        check("sb_stall", stall, 1);
        next_cycle();
        bus_ack = 1'b1;
        sample();
        check("sb_bus_we", bus_we, 1);
        check("sb_bus_be", bus_be, 32'h2);
        check("sb_bus_wdata", bus_wdata, 32'hEFEF_EFEF);
        check("sb_bus_addr", bus_addr, 32'h0000_3000);
        next_cycle();
        sample();
        check("sb_done", done, 1);
        check("sb_rdata_hold", rdata, 32'h0000_9ABC);
        next_cycle();
        memWrite = 1'b0;

        // sw at 0x3004 with memRead also high: treated as a store
        next_cycle();
        memWrite = 1'b1; memRead = 1'b1; memRWSize = 3'b010; addr = 32'h0000_3004; wdata = 32'hDEAD_BEEF;
        sample();
        next_cycle();
        bus_ack = 1'b1;
        sample();
        check("sw_bus_we", bus_we, 1);
        check("sw_bus_be", bus_be, 32'hF);
        check("sw_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("sw_bus_addr", bus_addr, 32'h0000_3004);
        next_cycle();
        sample();
        check("sw_done", done, 1);
        next_cycle();
        memWrite = 1'b0; memRead = 1'b0;

        // Misaligned lw at 0x4002 and illegal size 011: fault, no bus access
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b010; addr = 32'h0000_4002;
        sample();
        check("mis_c1_stall", stall, 1);
        check("mis_c1_req", bus_req, 0);
        next_cycle();
        sample();
        check("mis_done", done, 1);
        check("mis_fault", fault, 1);
        check("mis_rdata", rdata, 0);
        check("mis_req", bus_req, 0);
        check("mis_stall", stall, 0);
        next_cycle();
        memRead = 1'b0;
        sample();
        check("mis_fault_clear", {fault, done}, 0);
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b011; addr = 32'h0000_4000;
        sample();
        check("ill_c1_req", bus_req, 0);
        next_cycle();
        sample();
        check("ill_done_fault", {done, fault, bus_req}, 32'h6);
        check("ill_rdata", rdata, 0);
        next_cycle();
        memRead = 1'b0;

        // Timeout: load with no ack, TIMEOUT_CYCLES=4
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b010; addr = 32'h0000_5000;
        sample();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sample();
            check("to_req_high", bus_req, 1);
            check("to_no_done", done, 0);
        end
        next_cycle();
        sample();
        check("to_done", done, 1);
        check("to_bus_err", bus_err, 1);
        check("to_rdata", rdata, 0);
        check("to_req_drop", bus_req, 0);
        next_cycle();
        memRead = 1'b0;
        sample();
        check("to_err_clear", bus_err, 0);
        next_cycle();
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        sample();
        next_cycle();
        sample();
        check("late_ack_ignored", {done, stall, bus_req, bus_err}, 0);
        check("late_ack_rdata", rdata, 0);

        // Reset during the second BUS cycle, then a clean lw
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b010; addr = 32'h0000_6000;
        sample();
        next_cycle();
        sample();
        check("rstmid_bus1_req", bus_req, 1);
        next_cycle();
        rst = 1'b1;
        sample();
        check("rstmid_bus2_req", bus_req, 1);
        next_cycle();
        rst = 1'b0; memRead = 1'b0;
        sample();
        check("rstmid_req_drop", bus_req, 0);
        check("rstmid_no_done", done, 0);
        next_cycle();
        sample();
        check("rstmid_still_idle", {done, stall, bus_req}, 0);
        next_cycle();
        memRead = 1'b1; memRWSize = 3'b010; addr = 32'h0000_7000;
        sample();
        check("post_lw_stall", stall, 1);
        next_cycle();
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        sample();
        check("post_lw_addr", bus_addr, 32'h0000_7000);
        next_cycle();
        sample();
        check("post_lw_done", done, 1);
        check("post_lw_rdata", rdata, 32'h1234_5678);
        next_cycle();
        memRead = 1'b0;
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
